trace_buffer: RTL and testbench

Parametrised debug-trace capture unit for the pipelined MIPS core. It captures per-cycle events from NCH prioritised channels, stamps each with a tag, cycle count and pclow, and buffers the records in a DEPTH-entry FIFO. Records are drained as a byte stream to the UART transmitter through a valid/ready handshake. It replaces the single-register, fixed-width show register with lossless buffering, variable record length and drop accounting.

---
 rtl/trace_buffer.sv | 131 +++++++++++++
 tb/tb_trace_buffer.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/trace_buffer.sv
// trace_buffer: captures prioritised per-cycle events as tagged records in a FIFO
// and drains them as a byte stream over a valid/ready handshake.
module trace_buffer #(
  parameter int NCH = 4,
  parameter int PW = 96,
  parameter int DEPTH = 8,
  parameter int LW = $clog2(PW/8+1)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     freeze,
  input  logic [NCH-1:0]           ev_valid,
  input  logic [NCH*PW-1:0]        ev_payload,
  input  logic [NCH*LW-1:0]        ev_len,
  input  logic [7:0]               pclow,
  output logic [7:0]               tx_data,
  output logic                     tx_valid,
  input  logic                     tx_ready,
  output logic [$clog2(DEPTH):0]   level,
  output logic [15:0]              dropped
);
  localparam int AW = $clog2(DEPTH);
  localparam int NB = PW/8;
  localparam int IW = $clog2(NB+3);
  typedef enum logic {IDLE, SEND} state_t;
  typedef struct packed {
    logic [7:0]    tag;
    logic [7:0]    cnt;
    logic [7:0]    pc;
    logic [PW-1:0] pay;
    logic [LW-1:0] len;
  } rec_t;
  state_t state_q, state_d;
  rec_t mem_q [DEPTH];
  rec_t head_q, head_d, entry;
  logic [7:0] cnt_q, cnt_d;
  logic sticky_q, sticky_d;
  logic [AW:0] level_q, level_d;
  logic [15:0] dropped_q, dropped_d;
  logic [AW-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [IW-1:0] idx_q, idx_d, bi;
  logic [3:0] win;
  logic [4:0] nset, ndrop;
  logic [LW-1:0] wlen;
  logic [PW-1:0] wpay;
  logic capture, push, pop;
  logic [16:0] dsum;
  // Full is exactly the level MSB because DEPTH is a power of two.
  always_comb begin
    win = '0;
    wlen = '0;
    wpay = '0;
    nset = '0;
    for (int i = NCH-1; i >= 0; i--) begin
      if (ev_valid[i]) begin
        win = 4'(i);
        wlen = ev_len[i*LW +: LW];
        wpay = ev_payload[i*PW +: PW];
      end
      nset = nset + 5'(ev_valid[i]);
    end
    capture = ~freeze & |ev_valid;
    push = capture & ~level_q[AW];
    ndrop = capture ? nset - 5'(push) : 5'd0;
    entry.tag = {win + 4'd1, 3'b000, sticky_q | (nset > 5'd1)};
    entry.cnt = cnt_q;
    entry.pc = pclow;
    entry.pay = wpay;
    entry.len = (wlen > LW'(NB)) ? LW'(NB) : wlen;
    dsum = {1'b0, dropped_q} + 17'(ndrop);
    dropped_d = dsum[16] ? 16'hFFFF : dsum[15:0];
    sticky_d = push ? 1'b0 : sticky_q | (ndrop != 5'd0);
    cnt_d = cnt_q + 8'd1;
    wp_d = push ? wp_q + AW'(1) : wp_q;
    level_d = level_q + (AW+1)'(push) - (AW+1)'(pop);
  end
  always_comb begin
    state_d = state_q;
    idx_d = idx_q;
    head_d = head_q;
    rp_d = rp_q;
    pop = 1'b0;
    if (state_q == IDLE) begin
      if (level_q != '0) begin
        state_d = SEND;
        head_d = mem_q[rp_q];
        idx_d = '0;
      end
    end else if (tx_ready) begin
      pop = idx_q == IW'(head_q.len) + IW'(2);
      idx_d = idx_q + IW'(1);
      state_d = pop ? IDLE : SEND;
      rp_d = pop ? rp_q + AW'(1) : rp_q;
    end
    bi = IW'(head_q.len) + IW'(2) - idx_q;
    tx_valid = state_q == SEND;
    tx_data = !tx_valid ? 8'h00 :
              idx_q == IW'(0) ? head_q.tag :
              idx_q == IW'(1) ? head_q.cnt :
              idx_q == IW'(2) ? head_q.pc :
              8'(head_q.pay >> {bi, 3'b000});
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      head_q <= '0;
      cnt_q <= '0;
      sticky_q <= 1'b0;
      level_q <= '0;
      dropped_q <= '0;
      wp_q <= '0;
      rp_q <= '0;
      idx_q <= '0;
    end else begin
      state_q <= state_d;
      head_q <= head_d;
      cnt_q <= cnt_d;
      sticky_q <= sticky_d;
      level_q <= level_d;
      dropped_q <= dropped_d;
      wp_q <= wp_d;
      rp_q <= rp_d;
      idx_q <= idx_d;
    end
  end
  always_ff @(posedge clk) begin
    if (push && !reset) mem_q[wp_q] <= entry;
  end
  assign level = level_q;
  assign dropped = dropped_q;
endmodule

// File: tb/tb_trace_buffer.sv
// tb_trace_buffer: randomized and directed checks of trace_buffer against a queue-based record model.
module tb_trace_buffer;
  localparam int NCH = 4, PW = 96, DEPTH = 8, LW = 4, NB = 12;
  logic clk = 1'b0, reset = 1'b1, freeze = 1'b0, tx_ready = 1'b0;
  logic [NCH-1:0] ev_valid = '0;
  logic [NCH*PW-1:0] ev_payload = '0;
  logic [NCH*LW-1:0] ev_len = '0;
  logic [7:0] pclow = '0;
  logic [7:0] tx_data;
  logic tx_valid;
  logic [3:0] level;
  logic [15:0] dropped;
  int n_cmp = 0, n_err = 0;
  logic [7:0] exp_q[$];
  int rec_q[$];
  int m_level, m_drop, mn, mw, mlen, mpush, mpop, mdrops;
  bit m_sticky, stall;
  logic [7:0] m_cnt, stall_data, eb;

  always #5 clk = ~clk;

  trace_buffer #(.NCH(NCH), .PW(PW), .DEPTH(DEPTH), .LW(LW)) dut (
    .clk(clk), .reset(reset), .freeze(freeze), .ev_valid(ev_valid),
    .ev_payload(ev_payload), .ev_len(ev_len), .pclow(pclow), .tx_data(tx_data),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .level(level), .dropped(dropped)
  );

  // Reference model: each captured record becomes a list of expected bytes.
  always @(negedge clk) begin
    if (reset) begin
      exp_q.delete();
      rec_q.delete();
      m_level = 0;
      m_drop = 0;
      m_sticky = 0;
      m_cnt = 8'h00;
      stall = 0;
    end else begin
      n_cmp++;
      if (level !== 4'(m_level)) begin n_err++; $display("FAIL level: got %0d want %0d at %0t", level, m_level, $time); end
      n_cmp++;
      if (dropped !== 16'(m_drop)) begin n_err++; $display("FAIL dropped: got %0d want %0d at %0t", dropped, m_drop, $time); end
      if (stall) begin
        n_cmp++;
        if (tx_valid !== 1'b1 || tx_data !== stall_data) begin
          n_err++; $display("FAIL stall_hold: got v=%b d=%h want v=1 d=%h at %0t", tx_valid, tx_data, stall_data, $time);
        end
      end
      stall = (tx_valid === 1'b1) && !tx_ready;
      stall_data = tx_data;
      mpop = 0;
      if (tx_valid === 1'b1 && tx_ready) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++; $display("FAIL stream_byte: got unexpected %h want nothing at %0t", tx_data, $time);
        end else begin
          eb = exp_q.pop_front();
          if (tx_data !== eb) begin n_err++; $display("FAIL stream_byte: got %h want %h at %0t", tx_data, eb, $time); end
          rec_q[0] = rec_q[0] - 1;
          if (rec_q[0] == 0) begin void'(rec_q.pop_front()); mpop = 1; end
        end
      end
      mpush = 0;
      mdrops = 0;
      if (!freeze && ev_valid != '0) begin
        mn = $countones(ev_valid);
        mw = 0;
        while (!ev_valid[mw]) mw++;
        if (m_level < DEPTH) begin
          mpush = 1;
          mdrops = mn - 1;
          mlen = int'(ev_len[mw*LW +: LW]);
          if (mlen > NB) mlen = NB;
          exp_q.push_back({4'(mw + 1), 3'b000, 1'(m_sticky || mn > 1)});
          exp_q.push_back(m_cnt);
          exp_q.push_back(pclow);
          for (int k = mlen - 1; k >= 0; k--) exp_q.push_back(ev_payload[mw*PW + k*8 +: 8]);
          rec_q.push_back(3 + mlen);
        end else mdrops = mn;
        m_sticky = (mpush == 0);
      end
      m_level = m_level + mpush - mpop;
      m_drop = ((m_drop + mdrops) > 65535) ? 65535 : m_drop + mdrops;
      m_cnt = m_cnt + 8'd1;
    end
  end

  task automatic cyc(input int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic do_reset();
    ev_valid = '0; freeze = 1'b0; reset = 1'b1;
    cyc(1);
    reset = 1'b0;
  endtask

  task automatic rand_ev();
    for (int i = 0; i < NCH*PW/32; i++) ev_payload[i*32 +: 32] = $urandom;
    for (int i = 0; i < NCH; i++) ev_len[i*LW +: LW] = LW'($urandom_range(0, 15));
    pclow = 8'($urandom);
  endtask

  task automatic wait_idle(input string nm, input int budget);
    int t;
    t = 0;
    while ((level !== 4'd0 || tx_valid !== 1'b0) && t < budget) begin cyc(1); t++; end
    n_cmp++;
    if (t >= budget) begin n_err++; $display("FAIL %s_drain_timeout: got level=%0d want 0", nm, level); end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    cyc(2);
    n_cmp++;
    if (tx_valid !== 1'b0 || tx_data !== 8'h00 || level !== 4'd0 || dropped !== 16'd0) begin
      n_err++; $display("FAIL reset_state: got v=%b d=%h l=%0d dr=%0d want 0", tx_valid, tx_data, level, dropped);
    end
    reset = 1'b0;
  endtask

  task automatic test_single();
    logic [7:0] exp_b [7];
    exp_b = '{8'h10, 8'h05, 8'h12, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
    do_reset();
    tx_ready = 1'b1;
    cyc(5);
    rand_ev();
    ev_payload[31:0] = 32'hAABBCCDD;
    ev_len[LW-1:0] = LW'(4);
    pclow = 8'h12;
    ev_valid = 4'b0001;
    cyc(1);
    ev_valid = '0;
    n_cmp++;
    if (level !== 4'd1 || tx_valid !== 1'b0) begin n_err++; $display("FAIL single_n1: got l=%0d v=%b want 1 0", level, tx_valid); end
    cyc(1);
    for (int k = 0; k < 7; k++) begin
      n_cmp++;
      if (tx_valid !== 1'b1 || tx_data !== exp_b[k]) begin
        n_err++; $display("FAIL single_byte%0d: got v=%b d=%h want 1 %h", k, tx_valid, tx_data, exp_b[k]);
      end
      cyc(1);
    end
    n_cmp++;
    if (tx_valid !== 1'b0 || level !== 4'd0) begin n_err++; $display("FAIL single_end: got v=%b l=%0d want 0 0", tx_valid, level); end
  endtask

  task automatic test_priority();
    do_reset();
    tx_ready = 1'b1;
    rand_ev();
    ev_len[1*LW +: LW] = '0;
    ev_valid = 4'b0110;
    cyc(1);
    ev_valid = '0;
    n_cmp++;
    if (dropped !== 16'd1) begin n_err++; $display("FAIL prio_dropped: got %0d want 1", dropped); end
    cyc(1);
    n_cmp++;
    if (tx_valid !== 1'b1 || tx_data !== 8'h21) begin n_err++; $display("FAIL prio_tag1: got v=%b d=%h want 1 21", tx_valid, tx_data); end
    cyc(4);
    rand_ev();
    ev_valid = 4'b0100;
    cyc(1);
    ev_valid = '0;
    cyc(1);
    n_cmp++;
    if (tx_valid !== 1'b1 || tx_data !== 8'h30) begin n_err++; $display("FAIL prio_tag2: got v=%b d=%h want 1 30", tx_valid, tx_data); end
    wait_idle("prio", 40);
  endtask

  task automatic test_overflow();
    do_reset();
    tx_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      rand_ev();
      ev_valid = 4'b0001;
      cyc(1);
    end
    ev_valid = '0;
    n_cmp++;
    if (level !== 4'd8 || dropped !== 16'd2) begin n_err++; $display("FAIL ovf_full: got l=%0d dr=%0d want 8 2", level, dropped); end
    tx_ready = 1'b1;
    wait_idle("ovf", 300);
    rand_ev();
    ev_valid = 4'b0001;
    cyc(1);
    ev_valid = '0;
    cyc(1);
    n_cmp++;
    if (tx_valid !== 1'b1 || tx_data !== 8'h11) begin n_err++; $display("FAIL ovf_tag: got v=%b d=%h want 1 11", tx_valid, tx_data); end
    wait_idle("ovf2", 40);
  endtask

  task automatic test_backpressure();
    int total, hs, t;
    do_reset();
    total = 0;
    hs = 0;
    for (int i = 0; i < 5; i++) begin
      rand_ev();
      mw = $urandom_range(0, NCH - 1);
      mlen = $urandom_range(0, 12);
      ev_len[mw*LW +: LW] = LW'(mlen);
      total += 3 + mlen;
      ev_valid = '0;
      ev_valid[mw] = 1'b1;
      tx_ready = 1'($urandom_range(0, 1));
      if (tx_valid === 1'b1 && tx_ready) hs++;
      cyc(1);
    end
    ev_valid = '0;
    t = 0;
    while (hs < total && t < 1000) begin
      tx_ready = 1'($urandom_range(0, 1));
      if (tx_valid === 1'b1 && tx_ready) hs++;
      cyc(1);
      t++;
    end
    tx_ready = 1'b1;
    cyc(2);
    n_cmp++;
    if (hs != total) begin n_err++; $display("FAIL bp_bytes: got %0d want %0d", hs, total); end
    n_cmp++;
    if (exp_q.size() != 0 || tx_valid !== 1'b0) begin n_err++; $display("FAIL bp_leftover: got %0d bytes v=%b want 0 0", exp_q.size(), tx_valid); end
  endtask

  task automatic test_freeze();
    do_reset();
    tx_ready = 1'b0;
    rand_ev();
    ev_valid = 4'b0011;
    cyc(1);
    rand_ev();
    ev_valid = 4'b1000;
    cyc(1);
    freeze = 1'b1;
    for (int i = 0; i < 10; i++) begin
      rand_ev();
      ev_valid = (i % 2 == 0) ? 4'b0001 : 4'b1111;
      cyc(1);
    end
    ev_valid = '0;
    n_cmp++;
    if (level !== 4'd2 || dropped !== 16'd1) begin n_err++; $display("FAIL freeze_hold: got l=%0d dr=%0d want 2 1", level, dropped); end
    freeze = 1'b0;
    tx_ready = 1'b1;
    wait_idle("freeze", 100);
  endtask

  task automatic test_reset_mid();
    do_reset();
    tx_ready = 1'b1;
    rand_ev();
    ev_len[LW-1:0] = LW'(8);
    ev_valid = 4'b0001;
    cyc(1);
    ev_valid = '0;
    cyc(3);
    n_cmp++;
    if (tx_valid !== 1'b1) begin n_err++; $display("FAIL rmid_active: got v=%b want 1", tx_valid); end
    reset = 1'b1;
    cyc(1);
    reset = 1'b0;
    n_cmp++;
    if (tx_valid !== 1'b0 || level !== 4'd0) begin n_err++; $display("FAIL rmid_clear: got v=%b l=%0d want 0 0", tx_valid, level); end
    rand_ev();
    ev_len[LW-1:0] = '0;
    ev_valid = 4'b0001;
    cyc(1);
    ev_valid = '0;
    cyc(2);
    n_cmp++;
    if (tx_valid !== 1'b1 || tx_data !== 8'h00) begin n_err++; $display("FAIL rmid_counter: got v=%b d=%h want 1 00", tx_valid, tx_data); end
    wait_idle("rmid", 20);
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      rand_ev();
      ev_valid = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b0000;
      freeze = ($urandom_range(0, 7) == 0);
      tx_ready = ($urandom_range(0, 3) != 0);
      cyc(1);
    end
    ev_valid = '0;
    freeze = 1'b0;
    tx_ready = 1'b1;
    wait_idle("rand", 300);
    n_cmp++;
    if (exp_q.size() != 0) begin n_err++; $display("FAIL rand_leftover: got %0d bytes want 0", exp_q.size()); end
  endtask

  task automatic test_saturation();
    do_reset();
    tx_ready = 1'b0;
    ev_valid = '1;
    cyc(16400);
    ev_valid = '0;
    cyc(1);
    n_cmp++;
    if (dropped !== 16'hFFFF || level !== 4'd8) begin n_err++; $display("FAIL saturation: got dr=%h l=%0d want FFFF 8", dropped, level); end
    do_reset();
  endtask

  initial begin
    test_reset();
    test_single();
    test_priority();
    test_overflow();
    test_backpressure();
    test_freeze();
    test_reset_mid();
    test_random();
    test_saturation();
    cyc(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
